clock_divider_bank: RTL

Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the single fixed-divisor divider. Each channel derives a divided clock-enable waveform and a period tick from the one system clock. Divisor and high-time are loaded per channel through a valid/ready port and take effect only at a period boundary, so reconfiguration never produces runt pulses. It sits between the board clock input and the peripheral blocks (baud generators, refresh timers, blink logic) that each need their own rate.

---
 rtl/clock_divider_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: multi-channel runtime-programmable clock divider.
// Each channel produces a registered divided clock and a period-start tick.
// New divisor/high-count values are staged in a shadow copy and only take
// effect at a period boundary (or right away when the channel is idle), so
// a reconfiguration never produces a runt pulse.
module clock_divider_bank #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEFAULT_DIVISOR = 2,
  parameter int unsigned CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_SYS_CLOCK,
  input  logic                i_RESET,
  input  logic [CHANNELS-1:0] i_ENABLE,
  input  logic                i_LOAD_VALID,
  input  logic [CH_W-1:0]     i_LOAD_CHANNEL,
  input  logic [WIDTH-1:0]    i_LOAD_DIVISOR,
  input  logic [WIDTH-1:0]    i_LOAD_HIGH,
  output logic                o_LOAD_READY,
  output logic [CHANNELS-1:0] o_CLOCK,
  output logic [CHANNELS-1:0] o_TICK
);

  localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIVISOR);
  localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_DIVISOR / 2);

  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    div_q    [CHANNELS];
  logic [WIDTH-1:0]    div_d    [CHANNELS];
  logic [WIDTH-1:0]    high_q   [CHANNELS];
  logic [WIDTH-1:0]    high_d   [CHANNELS];
  logic [WIDTH-1:0]    sh_div_q [CHANNELS];
  logic [WIDTH-1:0]    sh_div_d [CHANNELS];
  logic [WIDTH-1:0]    sh_high_q[CHANNELS];
  logic [WIDTH-1:0]    sh_high_d[CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  // run_q: channel was counting after the previous edge; a fresh start
  // registers cnt = 0 instead of advancing so the first cycle ticks.
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] tick_q, tick_d;

  // Ready follows the pending flag of the addressed channel; unknown
  // channel indices stay ready and their loads fall on the floor.
  always_comb begin
    o_LOAD_READY = 1'b1;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (i_LOAD_CHANNEL == CH_W'(c)) begin
        o_LOAD_READY = !pend_q[c];
      end
    end
  end

  // Per-channel next state: load accept, shadow apply, counting, outputs.
  always_comb begin
    logic             sel;
    logic             apply;
    logic             last;
    logic             stopped;
    logic [WIDTH-1:0] h_eff;
    sel     = 1'b0;
    apply   = 1'b0;
    last    = 1'b0;
    stopped = 1'b0;
    h_eff   = '0;
    pend_d  = pend_q;
    run_d   = '0;
    clk_d   = '0;
    tick_d  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      cnt_d[c]     = cnt_q[c];
      div_d[c]     = div_q[c];
      high_d[c]    = high_q[c];
      sh_div_d[c]  = sh_div_q[c];
      sh_high_d[c] = sh_high_q[c];

      sel     = i_LOAD_VALID && (i_LOAD_CHANNEL == CH_W'(c)) && !pend_q[c];
      stopped = !i_ENABLE[c] || (div_q[c] == '0);
      last    = (cnt_q[c] == div_q[c] - WIDTH'(1));
      // Uses the pre-edge pending flag, so a load taken on a wrap edge
      // waits for the next boundary.
      apply   = pend_q[c] && (stopped || last);

      if (sel) begin
        sh_div_d[c]  = i_LOAD_DIVISOR;
        sh_high_d[c] = i_LOAD_HIGH;
        pend_d[c]    = 1'b1;
      end

      if (apply) begin
        div_d[c]  = sh_div_q[c];
        high_d[c] = sh_high_q[c];
        cnt_d[c]  = '0;
        pend_d[c] = 1'b0;
      end else if (stopped || !run_q[c] || last) begin
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + WIDTH'(1);
      end

      run_d[c]  = i_ENABLE[c] && (div_d[c] != '0);
      h_eff     = (high_d[c] > div_d[c]) ? div_d[c] : high_d[c];
      tick_d[c] = run_d[c] && (cnt_d[c] == '0);
      clk_d[c]  = run_d[c] && (cnt_d[c] >= div_d[c] - h_eff);
    end
  end

  // State registers; reset restores defaults and drops any pending load.
  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        cnt_q[c]     <= '0;
        div_q[c]     <= DefDiv;
        high_q[c]    <= DefHigh;
        sh_div_q[c]  <= DefDiv;
        sh_high_q[c] <= DefHigh;
      end
      pend_q <= '0;
      run_q  <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        cnt_q[c]     <= cnt_d[c];
        div_q[c]     <= div_d[c];
        high_q[c]    <= high_d[c];
        sh_div_q[c]  <= sh_div_d[c];
        sh_high_q[c] <= sh_high_d[c];
      end
      pend_q <= pend_d;
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign o_CLOCK = clk_q;
  assign o_TICK  = tick_q;

endmodule
